// File: rtl/seg_decoder.sv
// Seven-segment display decoder: recovers per-digit hex values and decimal
// points from observed multiplexed anode/segment lines, with frame presence reporting.
module seg_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned FRAME_CYCLES  = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an_in,
  input  logic [7:0]  seg_in,
  output logic [15:0] digit_val,
  output logic [3:0]  dp_val,
  output logic [3:0]  digit_present,
  output logic        frame_valid,
  output logic        pattern_err
);

  typedef enum logic {
    COUNT = 1'b0,
    HELD  = 1'b1
  } state_e;

  localparam logic [7:0]  STABLE_LIM = 8'(STABLE_CYCLES);
  localparam logic [15:0] FRAME_LAST = 16'(FRAME_CYCLES - 1);

  // Returns {hit, nibble} for a g..a segment pattern.
  function automatic logic [4:0] seg_lookup(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h3F:   r = {1'b1, 4'h0};
      7'h06:   r = {1'b1, 4'h1};
      7'h5B:   r = {1'b1, 4'h2};
      7'h4F:   r = {1'b1, 4'h3};
      7'h66:   r = {1'b1, 4'h4};
      7'h6D:   r = {1'b1, 4'h5};
      7'h7D:   r = {1'b1, 4'h6};
      7'h07:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h6F:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'hA};
      7'h7C:   r = {1'b1, 4'hB};
      7'h39:   r = {1'b1, 4'hC};
      7'h5E:   r = {1'b1, 4'hD};
      7'h79:   r = {1'b1, 4'hE};
      7'h71:   r = {1'b1, 4'hF};
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [3:0]  an_s1_q, an_s2_q;
  logic [7:0]  seg_s1_q, seg_s2_q;
  logic [3:0]  prev_an_q;
  logic [7:0]  prev_seg_q;
  logic [7:0]  cnt_q, cnt_d;
  state_e      state_q, state_d;
  logic        reach_stable;
  logic        pair_chg;
  logic        accept_d;
  logic        acc_q;
  logic [3:0]  acc_an_q;
  logic [7:0]  acc_seg_q;
  logic [4:0]  lookup;
  logic        multi_hot;
  logic [3:0]  wr_mask;
  logic        err_d;
  logic [15:0] digit_val_q, digit_val_d;
  logic [3:0]  dp_q, dp_d;
  logic [3:0]  seen_q, seen_d;
  logic [3:0]  present_q, present_d;
  logic [15:0] frame_q, frame_d;
  logic        tc;
  logic        frame_valid_q;
  logic        pattern_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1_q    <= '0;
      an_s2_q    <= '0;
      seg_s1_q   <= '0;
      seg_s2_q   <= '0;
      prev_an_q  <= '0;
      prev_seg_q <= '0;
    end else begin
      an_s1_q    <= an_in;
      an_s2_q    <= an_s1_q;
      seg_s1_q   <= seg_in;
      seg_s2_q   <= seg_s1_q;
      prev_an_q  <= an_s2_q;
      prev_seg_q <= seg_s2_q;
    end
  end

  assign pair_chg     = (an_s2_q != prev_an_q) || (seg_s2_q != prev_seg_q);
  assign reach_stable = (state_q == COUNT) && !pair_chg && ((cnt_q + 8'd1) == STABLE_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= COUNT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COUNT:   if (reach_stable) state_d = HELD;
      HELD:    if (pair_chg)     state_d = COUNT;
      default: state_d = COUNT;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    accept_d = 1'b0;
    if (pair_chg) begin
      cnt_d = 8'd1;
    end else if (state_q == COUNT) begin
      cnt_d    = cnt_q + 8'd1;
      accept_d = reach_stable;
    end
  end

  // The accepted pair is registered so the decode lands one edge after the decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      acc_q     <= 1'b0;
      acc_an_q  <= '0;
      acc_seg_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= accept_d;
      if (accept_d) begin
        acc_an_q  <= an_s2_q;
        acc_seg_q <= seg_s2_q;
      end
    end
  end

  assign lookup    = seg_lookup(acc_seg_q[6:0]);
  assign multi_hot = (acc_an_q & (acc_an_q - 4'd1)) != 4'd0;

  always_comb begin
    wr_mask = '0;
    err_d   = 1'b0;
    if (acc_q && (acc_an_q != 4'd0)) begin
      if (multi_hot)      err_d   = 1'b1;
      else if (lookup[4]) wr_mask = acc_an_q;
      else                err_d   = 1'b1;
    end
  end

  always_comb begin
    digit_val_d = digit_val_q;
    dp_d        = dp_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (wr_mask[i]) begin
        digit_val_d[4*i +: 4] = lookup[3:0];
        dp_d[i]               = acc_seg_q[7];
      end
    end
  end

  // A write landing on the terminal count belongs to the frame that is closing.
  assign tc = (frame_q == FRAME_LAST);

  always_comb begin
    frame_d   = tc ? '0 : frame_q + 16'd1;
    seen_d    = tc ? '0 : (seen_q | wr_mask);
    present_d = tc ? (seen_q | wr_mask) : present_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_val_q   <= '0;
      dp_q          <= '0;
      seen_q        <= '0;
      present_q     <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      pattern_err_q <= 1'b0;
    end else begin
      digit_val_q   <= digit_val_d;
      dp_q          <= dp_d;
      seen_q        <= seen_d;
      present_q     <= present_d;
      frame_q       <= frame_d;
      frame_valid_q <= tc;
      pattern_err_q <= err_d;
    end
  end

  assign digit_val     = digit_val_q;
  assign dp_val        = dp_q;
  assign digit_present = present_q;
  assign frame_valid   = frame_valid_q;
  assign pattern_err   = pattern_err_q;

endmodule

// File: tb/tb_seg_decoder.sv
// Directed self-checking bench for seg_decoder (STABLE_CYCLES=4, FRAME_CYCLES=64).
module tb_seg_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  an_in = '0;
  logic [7:0]  seg_in = '0;
  logic [15:0] digit_val;
  logic [3:0]  dp_val;
  logic [3:0]  digit_present;
  logic        frame_valid;
  logic        pattern_err;

  int unsigned n_pass = 0;
  int unsigned n_checks = 0;
  int unsigned fv_cnt = 0;
  int unsigned pe_cnt = 0;
  int unsigned pe_base;

  seg_decoder #(
    .STABLE_CYCLES(4),
    .FRAME_CYCLES (64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .an_in        (an_in),
    .seg_in       (seg_in),
    .digit_val    (digit_val),
    .dp_val       (dp_val),
    .digit_present(digit_present),
    .frame_valid  (frame_valid),
    .pattern_err  (pattern_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid) fv_cnt <= fv_cnt + 1;
      if (pattern_err) pe_cnt <= pe_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] an, input logic [7:0] seg);
    an_in  = an;
    seg_in = seg;
  endtask

  // Leaves time #1 after the edge that raised frame_valid.
  task automatic wait_frame(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 150 && !found; i++) begin
      tick(1);
      if (frame_valid) found = 1'b1;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  initial begin
    // Reset state
    tick(3);
    chk("rst_digit_val", 32'(digit_val), 32'h0);
    chk("rst_dp_val", 32'(dp_val), 32'h0);
    chk("rst_present", 32'(digit_present), 32'h0);
    chk("rst_frame_valid", 32'(frame_valid), 32'h0);
    chk("rst_pattern_err", 32'(pattern_err), 32'h0);
    rst_n = 1'b1;
    tick(3);

    // Single digit with decimal point: write lands exactly 7 cycles after the change
    drive(4'b0001, 8'h86);
    tick(6);
    chk("lat_before", 32'(digit_val[3:0]), 32'h0);
    tick(1);
    chk("lat_digit0", 32'(digit_val[3:0]), 32'h1);
    chk("lat_dp0", 32'(dp_val[0]), 32'h1);
    tick(10);
    chk("hold_digit_val", 32'(digit_val), 32'h0001);
    chk("hold_no_err", 32'(pe_cnt), 32'h0);

    // Four-digit scan inside one frame
    wait_frame("scan_align");
    drive(4'b0001, 8'h3F); tick(8);
    drive(4'b0010, 8'h5B); tick(8);
    drive(4'b0100, 8'h4F); tick(8);
    drive(4'b1000, 8'h66); tick(8);
    drive(4'b0000, 8'h00);
    wait_frame("scan_frame");
    chk("scan_present", 32'(digit_present), 32'hF);
    chk("scan_digit_val", 32'(digit_val), 32'h4320);
    chk("scan_dp_val", 32'(dp_val), 32'h0);
    tick(1);
    chk("frame_pulse_width", 32'(frame_valid), 32'h0);

    // Illegal segment pattern on digit 1
    pe_base = pe_cnt;
    drive(4'b0010, 8'h00); tick(8);
    drive(4'b0000, 8'h00); tick(4);
    chk("badpat_err_cnt", pe_cnt - pe_base, 32'd1);
    chk("badpat_digit1", 32'(digit_val[7:4]), 32'h2);
    wait_frame("badpat_frame");
    chk("badpat_present1", 32'(digit_present[1]), 32'h0);

    // Multi-hot select, then a select with segments toggling faster than the filter
    pe_base = pe_cnt;
    drive(4'b0110, 8'h3F); tick(8);
    chk("multihot_err_cnt", pe_cnt - pe_base, 32'd1);
    chk("multihot_digit_val", 32'(digit_val), 32'h4320);
    pe_base = pe_cnt;
    for (int i = 0; i < 10; i++) begin
      drive(4'b0100, (i % 2 == 0) ? 8'h06 : 8'h5B);
      tick(2);
    end
    drive(4'b0000, 8'h00); tick(8);
    chk("toggle_no_err", pe_cnt - pe_base, 32'd0);
    chk("toggle_digit_val", 32'(digit_val), 32'h4320);

    // Write landing on the terminal-count edge
    wait_frame("tc_align");
    tick(57);
    drive(4'b0100, 8'h66);
    tick(7);
    chk("tc_frame_valid", 32'(frame_valid), 32'h1);
    chk("tc_present", 32'(digit_present), 32'h4);
    chk("tc_digit_val", 32'(digit_val), 32'h4420);
    drive(4'b0000, 8'h00);
    wait_frame("tc_next_frame");
    chk("tc_seen_cleared", 32'(digit_present), 32'h0);

    // Asynchronous reset mid-frame with nonzero outputs
    tick(5);
    drive(4'b0001, 8'h5B);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_digit_val", 32'(digit_val), 32'h0);
    chk("arst_dp_val", 32'(dp_val), 32'h0);
    chk("arst_present", 32'(digit_present), 32'h0);
    chk("arst_frame_valid", 32'(frame_valid), 32'h0);
    chk("arst_pattern_err", 32'(pattern_err), 32'h0);
    tick(3);
    rst_n = 1'b1;
    tick(6);
    chk("arst_lat_before", 32'(digit_val), 32'h0);
    tick(1);
    chk("arst_lat_accept", 32'(digit_val), 32'h0002);
    chk("arst_lat_dp", 32'(dp_val), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
